// File: rtl/spi_master_pkg.sv
//------------------------------------------------------------------------------
// spi_master_pkg : shared widths, defaults and FSM state type for the SPI master
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package spi_master_pkg;
  localparam int DEF_MAX_DATA_WIDTH = 32;
  localparam int BPW_W              = 5;
  localparam int DIV_W              = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;
endpackage

`default_nettype wire

// File: rtl/spi_clk_gen.sv
//------------------------------------------------------------------------------
// spi_clk_gen : half-period divider giving SCK phase and leading/trailing strobes
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_clk_gen
  import spi_master_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             phase_o,
  output logic             lead_o,
  output logic             trail_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             tick;

  always_comb begin
    tick    = en_i && (cnt_q == div_i);
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else if (en_i) begin
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Phase 0->1 boundary is the leading SCK edge, 1->0 the trailing one.
  assign phase_o = phase_q;
  assign lead_o  = tick & ~phase_q;
  assign trail_o = tick &  phase_q;

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
//------------------------------------------------------------------------------
// spi_master : single-word SPI master, 1..MAX_DATA_WIDTH bits, MSB first, modes 0-3
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_master
  import spi_master_pkg::*;
#(
  parameter int MAX_DATA_WIDTH = DEF_MAX_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic [BPW_W-1:0]          bits_per_word,
  input  logic [DIV_W-1:0]          div,
  input  logic [MAX_DATA_WIDTH-1:0] data_in,
  output logic [MAX_DATA_WIDTH-1:0] data_out,
  input  logic                      miso,
  output logic                      mosi,
  output logic                      sck,
  output logic                      busy,
  output logic                      new_data
);

  state_e                    state_q, state_d;
  logic                      start_q;
  logic                      cpol_q, cpol_d;
  logic                      cpha_q, cpha_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [BPW_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [MAX_DATA_WIDTH-1:0] tx_q, tx_d;
  logic [MAX_DATA_WIDTH-1:0] rx_q, rx_d;
  logic [MAX_DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                      mosi_q, mosi_d;
  logic                      new_data_q, new_data_d;

  logic                      phase, lead, trail;
  logic                      xfer, launch, done;
  logic [BPW_W-1:0]          shamt;
  logic [MAX_DATA_WIDTH-1:0] tx_aligned, rx_shift;

  spi_clk_gen u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .en_i    (xfer),
    .clr_i   (launch),
    .div_i   (div_q),
    .phase_o (phase),
    .lead_o  (lead),
    .trail_o (trail)
  );

  // TX word is left-aligned so the current bit is always the top bit.
  assign shamt      = BPW_W'(MAX_DATA_WIDTH - 1) - bits_per_word;
  assign tx_aligned = data_in << shamt;
  assign rx_shift   = {rx_q[MAX_DATA_WIDTH-2:0], miso};

  assign xfer   = (state_q == XFER);
  assign done   = xfer && trail && (bit_cnt_q == '0);
  assign launch = start && !start_q && (!xfer || done);

  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    mosi_d     = mosi_q;
    new_data_d = new_data_q;

    case (state_q)
      IDLE: ;
      XFER: begin
        if ((!cpha_q && lead) || (cpha_q && trail)) begin
          rx_d = rx_shift;
        end
        if ((!cpha_q && trail && !done) || (cpha_q && lead)) begin
          mosi_d = tx_q[MAX_DATA_WIDTH-1];
          tx_d   = tx_q << 1;
        end
        if (trail && (bit_cnt_q != '0)) begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
        if (done) begin
          state_d    = IDLE;
          mosi_d     = 1'b0;
          data_out_d = cpha_q ? rx_shift : rx_q;
          new_data_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A launch in the completion cycle overrides the return to idle.
    if (launch) begin
      state_d    = XFER;
      cpol_d     = cpol;
      cpha_d     = cpha;
      div_d      = div;
      bit_cnt_d  = bits_per_word;
      rx_d       = '0;
      new_data_d = 1'b0;
      if (cpha) begin
        mosi_d = 1'b0;
        tx_d   = tx_aligned;
      end else begin
        mosi_d = data_in[bits_per_word];
        tx_d   = tx_aligned << 1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      mosi_q     <= 1'b0;
      new_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      mosi_q     <= mosi_d;
      new_data_q <= new_data_d;
    end
  end

  assign busy     = xfer;
  assign sck      = xfer ? (cpol_q ^ phase) : cpol;
  assign mosi     = mosi_q;
  assign data_out = data_out_q;
  assign new_data = new_data_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
//------------------------------------------------------------------------------
// tb_spi_master : randomized self-checking bench with an SPI slave model
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_spi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic [4:0]  bpw = '0;
  logic [5:0]  dv = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        miso;
  logic        mosi;
  logic        sck;
  logic        busy;
  logic        new_data;
  logic        loop_en = 1'b0;
  logic        miso_drv = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  assign miso = loop_en ? mosi : miso_drv;

  always #25 clk = ~clk;

  spi_master dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cpol          (cpol),
    .cpha          (cpha),
    .bits_per_word (bpw),
    .div           (dv),
    .data_in       (din),
    .data_out      (dout),
    .miso          (miso),
    .mosi          (mosi),
    .sck           (sck),
    .busy          (busy),
    .new_data      (new_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Slave model: presents slave bits MSB first on miso, captures mosi at each
  // sample edge, and checks the word-level results against plain arithmetic.
  task automatic run_xfer(input string tag, input logic p, input logic h, input int nbits,
                          input int d, input logic [31:0] tx, input logic [31:0] slave,
                          input logic lb, input logic hold);
    logic [31:0] mask, exp_rx, mosi_seen;
    logic        prev_sck, prev_mosi;
    int          edges, busy_cyc, bit_i;
    mask   = (nbits == 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
    exp_rx = lb ? (tx & mask) : (slave & mask);
    @(negedge clk);
    cpol = p; cpha = h; bpw = 5'(nbits - 1); dv = 6'(d); din = tx; loop_en = lb;
    miso_drv = slave[nbits-1];
    @(negedge clk);
    check_eq({tag, " idle_sck"}, {31'b0, sck}, {31'b0, p});
    start = 1'b1;
    @(negedge clk);
    check_eq({tag, " launch_newdata"}, {31'b0, new_data}, 32'd0);
    if (!hold) start = 1'b0;
    prev_sck = sck; prev_mosi = mosi;
    edges = 0; busy_cyc = 0; bit_i = 0; mosi_seen = '0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (sck !== prev_sck) begin
        edges++;
        if ((!h && (edges % 2 == 1)) || (h && (edges % 2 == 0))) begin
          mosi_seen = {mosi_seen[30:0], prev_mosi};
          bit_i++;
          if (bit_i < nbits) miso_drv = slave[nbits-1-bit_i];
        end
      end
      prev_sck  = sck;
      prev_mosi = mosi;
      if (busy) busy_cyc++;
      else break;
      @(negedge clk);
    end
    check_eq({tag, " busy_cycles"}, busy_cyc, 2 * nbits * (d + 1));
    check_eq({tag, " sck_edges"}, edges, 2 * nbits);
    check_eq({tag, " mosi_word"}, mosi_seen, tx & mask);
    check_eq({tag, " data_out"}, dout, exp_rx);
    check_eq({tag, " new_data"}, {31'b0, new_data}, 32'd1);
    check_eq({tag, " end_sck"}, {31'b0, sck}, {31'b0, p});
    check_eq({tag, " end_mosi"}, {31'b0, mosi}, 32'd0);
  endtask

  initial begin
    #(50 * 90000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  hi_cnt;
    int  nb;
    cpol = 1'b1;
    #5 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst sck", {31'b0, sck}, 32'd1);
    check_eq("rst busy", {31'b0, busy}, 32'd0);
    check_eq("rst new_data", {31'b0, new_data}, 32'd0);
    check_eq("rst data_out", dout, 32'd0);
    check_eq("rst mosi", {31'b0, mosi}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("idle busy", {31'b0, busy}, 32'd0);
    check_eq("idle sck", {31'b0, sck}, 32'd1);
    check_eq("idle data_out", dout, 32'd0);
    check_eq("idle new_data", {31'b0, new_data}, 32'd0);

    run_xfer("m0_a5", 1'b0, 1'b0, 8, 0, 32'h0000_00A5, 32'h0, 1'b1, 1'b0);
    run_xfer("m3_dead", 1'b1, 1'b1, 32, 3, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
    run_xfer("m1_ones", 1'b0, 1'b1, 4, 1, 32'h0000_0006, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_xfer("m2_ones", 1'b1, 1'b0, 4, 2, 32'h0000_0009, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_xfer("m1_pat", 1'b0, 1'b1, 6, 0, 32'h0000_0015, 32'h0000_0032, 1'b0, 1'b0);
    run_xfer("m2_pat", 1'b1, 1'b0, 6, 1, 32'h0000_002A, 32'h0000_0019, 1'b0, 1'b0);
    run_xfer("one_bit", 1'b0, 1'b0, 1, 0, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      nb = $urandom_range(1, 32);
      run_xfer($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               nb, $urandom_range(0, 3), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end

    // start held high through completion must not retrigger
    run_xfer("hold", 1'b0, 1'b0, 5, 0, 32'h0000_0013, 32'h0000_000C, 1'b0, 1'b1);
    hi_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) hi_cnt++;
    end
    check_eq("hold no_retrigger", hi_cnt, 0);
    check_eq("hold new_data", {31'b0, new_data}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    check_eq("relaunch pre_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check_eq("relaunch busy", {31'b0, busy}, 32'd1);
    check_eq("relaunch new_data", {31'b0, new_data}, 32'd0);
    check_eq("relaunch data_out_stable", dout, 32'h0000_000C);
    start = 1'b0;
    for (int c = 0; c < 200 && busy; c++) @(negedge clk);
    check_eq("relaunch done", {31'b0, busy}, 32'd0);

    // reset mid-transfer
    @(negedge clk);
    cpol = 1'b1; cpha = 1'b0; bpw = 5'd15; dv = 6'd2; din = 32'h0000_F00F;
    start = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("abort pre_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort busy", {31'b0, busy}, 32'd0);
    check_eq("abort sck", {31'b0, sck}, 32'd1);
    check_eq("abort new_data", {31'b0, new_data}, 32'd0);
    check_eq("abort data_out", dout, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_abort busy", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
